float_recip_iter: RTL and testbench

//  Consumer end of the reciprocal path. Takes operand Sj and the approximate reciprocal from float_recip.

---
 rtl/float_recip_iter.sv | 227 ++++++++++++++++++++++
 tb/tb_float_recip_iter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_recip_iter.sv
// float_recip_iter: Newton-Raphson refinement of an approximate reciprocal
// on Cray 64-bit floats. Each step computes r' = r * (2 - a*r) using one
// shared multi-cycle shift-add mantissa multiplier that retires RB bits of
// the multiplier operand per cycle. Results leave through a valid/ready pair.
module float_recip_iter #(
    parameter int ITER = 1,
    parameter int RB   = 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [63:0] i_sj,
    input  logic [63:0] i_approx,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_result,
    output logic        o_err
);

    localparam int NSTEP = 48 / RB;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int CW    = $clog2(ITER + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(NSTEP - 1);
    localparam logic [CW-1:0] ITER_CNT  = CW'(ITER);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_CHK  = 3'd2,
        S_MUL2 = 3'd3,
        S_NORM = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // One multiplier step, MSB-first: shift the partial product up by RB
    // and add the multiplicand times the next RB-bit chunk of the multiplier.
    function automatic logic [95:0] mac_step(input logic [95:0] acc,
                                             input logic [47:0] mcand,
                                             input logic [RB-1:0] chunk);
        logic [95:0] sum;
        sum = acc << RB;
        for (int i = 0; i < RB; i++) begin
            sum = sum + (chunk[i] ? ({48'd0, mcand} << i) : 96'd0);
        end
        return sum;
    endfunction

    state_t        state_q;
    logic          idle_q;
    logic          valid_q;
    logic [63:0]   result_q;
    logic          err_q;
    logic          sa_q;
    logic [14:0]   ea_q;
    logic [47:0]   ma_q;
    logic          sr_q;
    logic [14:0]   er_q;
    logic [47:0]   mr_q;
    logic [95:0]   acc_q;
    logic [47:0]   mplier_q;
    logic [SW-1:0] step_q;
    logic [CW-1:0] cnt_q;

    logic [95:0]   acc_d;
    logic [CW-1:0] cnt_d;
    logic [16:0]   k_s;
    logic          chk_err_s;
    logic [95:0]   t_s;
    logic [47:0]   c48_s;
    logic [47:0]   norm_m_s;
    logic [14:0]   norm_e_s;
    logic          norm_err_s;

    assign o_ready  = idle_q & i_rst_n;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_err    = err_q;

    assign acc_d = mac_step(acc_q, mr_q, mplier_q[47 -: RB]);
    assign cnt_d = cnt_q + CW'(1);

    // Range/format check of a*r and the correction factor c = 2 - a*r
    always_comb begin
        k_s       = {2'b00, ea_q} + {2'b00, er_q} - 17'h08000;
        chk_err_s = 1'b0;
        t_s       = acc_q;
        if (!ma_q[47] || !mr_q[47] || (sa_q != sr_q)) begin
            chk_err_s = 1'b1;
        end else if (k_s == 17'd1) begin
            chk_err_s = 1'b0;
        end else if (k_s == 17'd2) begin
            chk_err_s = acc_q[95];
        end else begin
            chk_err_s = 1'b1;
        end
        // a*r in Q1.95: the Q0.96 product as-is when k=1, doubled when k=2
        if (k_s == 17'd2) begin
            t_s = acc_q << 1;
        end else begin
            t_s = acc_q;
        end
        c48_s = 48'((96'd0 - t_s) >> 48);
    end

    // Renormalise r*c (Q1.95) back to a 0.1xxx mantissa, truncating
    always_comb begin
        norm_m_s   = mr_q;
        norm_e_s   = er_q;
        norm_err_s = 1'b0;
        if (acc_q[95]) begin
            norm_m_s = acc_q[95:48];
            norm_e_s = er_q + 15'd1;
        end else if (acc_q[94]) begin
            norm_m_s = acc_q[94:47];
            norm_e_s = er_q;
        end else begin
            norm_err_s = 1'b1;
        end
    end

    // Control FSM plus datapath registers; every output is registered
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            idle_q   <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= 64'd0;
            err_q    <= 1'b0;
            sa_q     <= 1'b0;
            ea_q     <= 15'd0;
            ma_q     <= 48'd0;
            sr_q     <= 1'b0;
            er_q     <= 15'd0;
            mr_q     <= 48'd0;
            acc_q    <= 96'd0;
            mplier_q <= 48'd0;
            step_q   <= {SW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        sa_q     <= i_sj[63];
                        ea_q     <= i_sj[62:48];
                        ma_q     <= i_sj[47:0];
                        sr_q     <= i_approx[63];
                        er_q     <= i_approx[62:48];
                        mr_q     <= i_approx[47:0];
                        acc_q    <= 96'd0;
                        mplier_q <= i_sj[47:0];
                        step_q   <= {SW{1'b0}};
                        cnt_q    <= {CW{1'b0}};
                        idle_q   <= 1'b0;
                        state_q  <= S_MUL1;
                    end else begin
                        idle_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_MUL1, S_MUL2: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q << RB;
                    if (step_q == STEP_LAST) begin
                        step_q  <= {SW{1'b0}};
                        state_q <= (state_q == S_MUL1) ? S_CHK : S_NORM;
                    end else begin
                        step_q  <= step_q + SW'(1);
                        state_q <= state_q;
                    end
                end
                S_CHK: begin
                    if (chk_err_s) begin
                        result_q <= {sr_q, er_q, mr_q};
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        // second product r*c reuses mr as multiplicand
                        acc_q    <= 96'd0;
                        mplier_q <= c48_s;
                        step_q   <= {SW{1'b0}};
                        state_q  <= S_MUL2;
                    end
                end
                S_NORM: begin
                    if (norm_err_s) begin
                        result_q <= {sr_q, er_q, mr_q};
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        er_q  <= norm_e_s;
                        mr_q  <= norm_m_s;
                        cnt_q <= cnt_d;
                        if (cnt_d < ITER_CNT) begin
                            acc_q    <= 96'd0;
                            mplier_q <= ma_q;
                            step_q   <= {SW{1'b0}};
                            state_q  <= S_MUL1;
                        end else begin
                            result_q <= {sr_q, norm_e_s, norm_m_s};
                            err_q    <= 1'b0;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        idle_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_recip_iter.sv
// Bench for float_recip_iter: three configurations driven in lock-step,
// scoreboard queue filled at accept time, monitor pops on each new result.
module tb_float_recip_iter;

    localparam int NDUT = 3;

    typedef struct {
        int          dut;
        logic [63:0] res;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [63:0] i_sj;
    logic [63:0] i_approx;
    logic        dut_ready  [NDUT];
    logic        dut_valid  [NDUT];
    logic [63:0] dut_result [NDUT];
    logic        dut_err    [NDUT];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        mon_en = 1'b0;
    logic        hold_rdy = 1'b0;
    exp_t        sb [$];
    logic [63:0] last_res [NDUT];
    logic        last_err [NDUT];
    int          last_lat [NDUT];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        float_recip_iter #(
            .ITER((g == 1) ? 2 : 1),
            .RB  ((g == 2) ? 4 : 1)
        ) u_dut (
            .clk      (clk),
            .i_rst_n  (i_rst_n),
            .i_valid  (i_valid),
            .o_ready  (dut_ready[g]),
            .i_sj     (i_sj),
            .i_approx (i_approx),
            .o_valid  (dut_valid[g]),
            .i_ready  (i_ready),
            .o_result (dut_result[g]),
            .o_err    (dut_err[g])
        );
    end

    function automatic int iter_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int rb_of(input int d);
        return (d == 2) ? 4 : 1;
    endfunction

    // Reference: Newton steps on integer mantissas with full-width products
    function automatic void ref_model(input logic [63:0] a, input logic [63:0] r0,
                                      input int iter, input int rb,
                                      output logic [63:0] res, output logic err,
                                      output int lat);
        logic [63:0] r;
        logic [95:0] p, t, c, q;
        logic [96:0] two96;
        logic [47:0] ma, mr;
        int          k, step_len;
        r        = r0;
        ma       = a[47:0];
        step_len = 96 / rb + 2;
        res      = r0;
        err      = 1'b0;
        lat      = iter * step_len;
        two96    = 97'd1 << 96;
        for (int n = 1; n <= iter; n++) begin
            mr = r[47:0];
            p  = {48'd0, ma} * {48'd0, mr};
            k  = int'(a[62:48]) + int'(r[62:48]) - 32768;
            if (!ma[47] || !mr[47] || (a[63] != r[63]) || (k != 1 && k != 2) || (k == 2 && p[95])) begin
                err = 1'b1;
                res = r;
                lat = (n - 1) * step_len + 48 / rb + 1;
                return;
            end
            t = (k == 1) ? p : (p << 1);
            c = 96'(two96 - {1'b0, t});
            q = {48'd0, mr} * {48'd0, c[95:48]};
            if (q[95]) begin
                r = {r[63], r[62:48] + 15'd1, q[95:48]};
            end else if (q[94]) begin
                r = {r[63], r[62:48], q[94:47]};
            end else begin
                err = 1'b1;
                res = r;
                lat = n * step_len;
                return;
            end
        end
        res = r;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s dut%0d: actual %h required %h (t=%0t)", name, d, act, req, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    function automatic bit all_ready();
        return dut_ready[0] && dut_ready[1] && dut_ready[2];
    endfunction

    function automatic bit all_valid();
        return dut_valid[0] && dut_valid[1] && dut_valid[2];
    endfunction

    task automatic wait_idle();
        int t;
        t = 0;
        while (!all_ready() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            note_fail("idle_timeout");
            finish_sim();
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] r);
        exp_t e;
        int   acc;
        wait_idle();
        i_sj     = a;
        i_approx = r;
        i_valid  = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        acc     = cyc;
        for (int d = 0; d < NDUT; d++) begin
            ref_model(a, r, iter_of(d), rb_of(d), e.res, e.err, e.lat);
            e.dut = d;
            e.acc = acc;
            sb.push_back(e);
        end
    endtask

    // Downstream ready: random back-pressure unless held low
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop expected result on each new o_valid, then track hold/drop
    initial begin
        logic seen [NDUT];
        logic hs   [NDUT];
        exp_t cur  [NDUT];
        bit   found;
        for (int d = 0; d < NDUT; d++) begin
            seen[d] = 1'b0;
            hs[d]   = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                for (int d = 0; d < NDUT; d++) begin
                    seen[d] = 1'b0;
                    hs[d]   = 1'b0;
                end
            end else begin
                for (int d = 0; d < NDUT; d++) begin
                    if (hs[d]) begin
                        chk("valid_drop", d, {63'd0, dut_valid[d]}, 64'd0);
                        hs[d]   = 1'b0;
                        seen[d] = 1'b0;
                    end else if (dut_valid[d]) begin
                        if (!seen[d]) begin
                            found = 1'b0;
                            for (int i = 0; i < sb.size(); i++) begin
                                if (!found && sb[i].dut == d) begin
                                    cur[d] = sb[i];
                                    sb.delete(i);
                                    found = 1'b1;
                                end
                            end
                            if (!found) begin
                                note_fail("unexpected_valid");
                                cur[d].res = dut_result[d];
                                cur[d].err = dut_err[d];
                            end else begin
                                chk("result", d, dut_result[d], cur[d].res);
                                chk("err", d, {63'd0, dut_err[d]}, {63'd0, cur[d].err});
                                chk("latency", d, 64'(cyc - cur[d].acc), 64'(cur[d].lat));
                            end
                            last_res[d] = dut_result[d];
                            last_err[d] = dut_err[d];
                            last_lat[d] = cyc - cur[d].acc;
                            seen[d]     = 1'b1;
                        end else begin
                            chk("hold_result", d, dut_result[d], cur[d].res);
                            chk("hold_err", d, {63'd0, dut_err[d]}, {63'd0, cur[d].err});
                        end
                        chk("ready_in_done", d, {63'd0, dut_ready[d]}, 64'd0);
                        if (i_ready) hs[d] = 1'b1;
                    end
                end
            end
        end
    end

    // Global time limit
    initial begin
        #900000;
        note_fail("watchdog");
        finish_sim();
    end

    // Stimulus
    initial begin
        logic [47:0] ma, mr;
        logic [14:0] ea, er;
        logic        sa, sr;
        logic [95:0] quo;
        logic [63:0] diff;
        int          sel;

        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_sj     = 64'd0;
        i_approx = 64'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_valid", d, {63'd0, dut_valid[d]}, 64'd0);
            chk("rst_result", d, dut_result[d], 64'd0);
            chk("rst_err", d, {63'd0, dut_err[d]}, 64'd0);
            chk("rst_ready_low", d, {63'd0, dut_ready[d]}, 64'd0);
        end
        i_rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) chk("ready_after_rst", d, {63'd0, dut_ready[d]}, 64'd1);
        mon_en = 1'b1;

        // 2.0 with r=0.5: exact fixed point
        issue(64'h4002800000000000, 64'h4000800000000000);
        wait_idle();
        for (int d = 0; d < NDUT; d++) begin
            chk("t1_result", d, last_res[d], 64'h4000800000000000);
            chk("t1_err", d, {63'd0, last_err[d]}, 64'd0);
        end
        chk("t1_latency", 0, 64'(last_lat[0]), 64'd98);
        chk("t1_latency", 1, 64'(last_lat[1]), 64'd196);
        chk("t1_latency", 2, 64'(last_lat[2]), 64'd26);

        // 3.0 with a 16-bit approximation
        issue(64'h4002C00000000000, 64'h3FFFAAAA00000000);
        wait_idle();
        diff = (last_res[1] > 64'h3FFFAAAAAAAAAAAA) ? (last_res[1] - 64'h3FFFAAAAAAAAAAAA)
                                                    : (64'h3FFFAAAAAAAAAAAA - last_res[1]);
        n_checks++;
        if (diff > 64'd2) begin
            n_errors++;
            $display("FAIL t2_within_2lsb dut1: actual %h required 3fffaaaaaaaaaaaa +/-2", last_res[1]);
        end
        chk("t2_latency", 1, 64'(last_lat[1]), 64'd196);

        // Errors: zero approximation, then sign mismatch
        issue(64'h4002800000000000, 64'h0000000000000000);
        wait_idle();
        for (int d = 0; d < NDUT; d++) begin
            chk("t3_zero_err", d, {63'd0, last_err[d]}, 64'd1);
            chk("t3_zero_result", d, last_res[d], 64'd0);
        end
        chk("t3_zero_latency", 0, 64'(last_lat[0]), 64'd49);
        chk("t3_zero_latency", 2, 64'(last_lat[2]), 64'd13);
        issue(64'h4002800000000000, 64'hBFFF800000000000);
        wait_idle();
        for (int d = 0; d < NDUT; d++) chk("t3_sign_err", d, {63'd0, last_err[d]}, 64'd1);

        // Back-pressure at DONE with ignored i_valid pulses
        hold_rdy = 1'b1;
        issue(64'h4002C00000000000, 64'h3FFFAAAA00000000);
        begin
            int t;
            t = 0;
            while (!all_valid() && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) begin
                note_fail("t4_valid_timeout");
                finish_sim();
            end
        end
        repeat (5) begin
            i_valid = 1'b1;
            i_sj    = {$urandom, $urandom};
            for (int d = 0; d < NDUT; d++) chk("t4_ready_low", d, {63'd0, dut_ready[d]}, 64'd0);
            @(negedge clk);
            i_valid = 1'b0;
        end
        hold_rdy = 1'b0;
        wait_idle();

        // Reset in the middle of the second multiply
        issue(64'h4002800000000000, 64'h4000800000000000);
        repeat (60) @(negedge clk);
        mon_en  = 1'b0;
        i_rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("t5_rst_valid", d, {63'd0, dut_valid[d]}, 64'd0);
            chk("t5_rst_result", d, dut_result[d], 64'd0);
        end
        sb.delete();
        i_rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        issue(64'h4002800000000000, 64'h4000800000000000);
        wait_idle();
        for (int d = 0; d < NDUT; d++) chk("t5_rerun_result", d, last_res[d], 64'h4000800000000000);

        // Random operand pairs
        for (int i = 0; i < 40; i++) begin
            ma  = {1'b1, 15'($urandom), 32'($urandom)};
            ea  = 15'($urandom_range(32'h3000, 32'h5000));
            sa  = 1'($urandom);
            sr  = sa;
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                quo = (96'd1 << 95) / {48'd0, ma};
                mr  = (quo > 96'h0000_0000_0000_FFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : quo[47:0];
                mr  = mr ^ {40'd0, 8'($urandom)};
                er  = 15'(32769 - int'(ea));
            end else if (sel < 8) begin
                mr = {1'b1, 15'($urandom), 32'($urandom)};
                er = 15'(32768 + $urandom_range(1, 2) - int'(ea));
            end else if (sel == 8) begin
                mr = {16'($urandom), 32'($urandom)};
                er = 15'(32769 - int'(ea));
                sr = 1'($urandom);
            end else begin
                mr = {1'b1, 15'($urandom), 32'($urandom)};
                er = 15'($urandom);
            end
            issue({sa, ea, ma}, {sr, er, mr});
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", 0, 64'(sb.size()), 64'd0);
        finish_sim();
    end

endmodule
